// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling from a single
// bit-period counter, one-entry holding register with valid/ready handoff.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic            rx_m, rx_s, rx_d;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            deliver, ferr;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shreg_n = shreg;
    deliver = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        // edge-triggered so a line stuck low never re-arms the receiver
        if (rx_d && !rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n        = '0;
          shreg_n[idx] = rx_s;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_s) deliver = 1'b1;
          else      ferr    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      rx_d          <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      data          <= 8'h00;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_m          <= rx;
      rx_s          <= rx_m;
      rx_d          <= rx_s;
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      shreg         <= shreg_n;
      framing_error <= ferr;
      overrun       <= deliver && valid && !ready;
      // a delivery coinciding with acceptance of the old byte reloads in place
      if (deliver && (!valid || ready)) begin
        data  <= shreg;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at CLKS_PER_BIT=4: frame table plus corner sequences,
// with accepted bytes checked against a scoreboard queue.
module tb_uart_receiver;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, rx, ready;
  logic [7:0] data;
  logic       valid, framing_error, overrun;

  int tests = 0, fails = 0;
  int fe_cnt = 0, ov_cnt = 0, vld_cyc = 0;
  logic [7:0] sbq[$];
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;

  uart_receiver #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .framing_error(framing_error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // leaves rx at the stop-bit value; caller decides what follows
  task automatic send_bits(logic [7:0] b, logic stop);
    rx = 1'b0;
    repeat (N) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (N) tick();
    end
    rx = stop;
    repeat (N) tick();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (valid && ready) begin
        if (sbq.size() == 0) chk("accept_unexpected", 32'd1, 32'd0);
        else chk("accept_data", data, sbq.pop_front());
      end
      if (valid) vld_cyc++;
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (framing_error || overrun) chk("fe_ov_excl", framing_error & overrun, 0);
      if (pv && !pr) chk("hold_data", data, pd);
      pv = valid; pr = ready; pd = data;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_fe;
    int         exp_vcyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fe0, ov0, vc0;
    vecs[0] = '{8'hAA, 1'b1, 0, 1};
    vecs[1] = '{8'h00, 1'b1, 0, 1};
    vecs[2] = '{8'hFF, 1'b1, 0, 1};
    vecs[3] = '{8'h3C, 1'b1, 0, 1};
    vecs[4] = '{8'h81, 1'b0, 1, 0};
    vecs[5] = '{8'hA5, 1'b1, 0, 1};

    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    repeat (3) tick();
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_fe", framing_error, 0);
    chk("rst_ov", overrun, 0);
    rst = 1'b0;
    repeat (4) tick();

    // table: single frames, consumer always ready
    ready = 1'b1;
    foreach (vecs[i]) begin
      fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vld_cyc;
      if (vecs[i].stop) sbq.push_back(vecs[i].d);
      send_bits(vecs[i].d, vecs[i].stop);
      rx = 1'b1;
      repeat (4) tick();
      chk($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
      chk($sformatf("vec%0d_ov", i), ov_cnt - ov0, 0);
      chk($sformatf("vec%0d_vcyc", i), vld_cyc - vc0, vecs[i].exp_vcyc);
      chk($sformatf("vec%0d_valid", i), valid, 0);
      chk($sformatf("vec%0d_sbq", i), sbq.size(), 0);
    end

    // back-to-back with consumer stalled: second byte overruns
    ready = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    sbq.push_back(8'h5C);
    send_bits(8'h5C, 1'b1);
    send_bits(8'h3F, 1'b1);
    rx = 1'b1;
    repeat (4) tick();
    chk("ovr_count", ov_cnt - ov0, 1);
    chk("ovr_fe", fe_cnt - fe0, 0);
    chk("ovr_valid", valid, 1);
    chk("ovr_data", data, 8'h5C);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("ovr_drain_valid", valid, 0);
    chk("ovr_drain_sbq", sbq.size(), 0);

    // one-cycle glitch is a false start
    fe0 = fe_cnt; vc0 = vld_cyc;
    rx = 1'b0; tick(); rx = 1'b1;
    repeat (20) tick();
    chk("glitch_fe", fe_cnt - fe0, 0);
    chk("glitch_vcyc", vld_cyc - vc0, 0);
    chk("glitch_valid", valid, 0);

    // bad stop with line held low: single error, no re-arm until a fresh edge
    ready = 1'b1;
    fe0 = fe_cnt; vc0 = vld_cyc;
    send_bits(8'h81, 1'b0);
    repeat (20) tick();
    chk("brk_fe", fe_cnt - fe0, 1);
    chk("brk_valid", valid, 0);
    rx = 1'b1;
    repeat (8) tick();
    chk("brk_fe_after", fe_cnt - fe0, 1);
    chk("brk_vcyc", vld_cyc - vc0, 0);
    sbq.push_back(8'h42);
    send_bits(8'h42, 1'b1);
    rx = 1'b1;
    repeat (4) tick();
    chk("brk_next_sbq", sbq.size(), 0);
    chk("brk_next_fe", fe_cnt - fe0, 1);

    // reset in the middle of data bit 4 of 0xFF
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vld_cyc;
    rx = 1'b0; repeat (N) tick();
    rx = 1'b1; repeat (4 * N + 1) tick();
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    repeat (5 * N) tick();
    chk("abort_valid", valid, 0);
    chk("abort_data", data, 8'h00);
    chk("abort_fe", fe_cnt - fe0, 0);
    chk("abort_ov", ov_cnt - ov0, 0);
    chk("abort_vcyc", vld_cyc - vc0, 0);
    ready = 1'b0;
    sbq.push_back(8'h01);
    send_bits(8'h01, 1'b1);
    repeat (4) tick();
    chk("post_rst_valid", valid, 1);
    chk("post_rst_data", data, 8'h01);
    ready = 1'b1; tick(); ready = 1'b0;

    // delivery on the same edge the old byte is accepted
    ov0 = ov_cnt;
    sbq.push_back(8'h11);
    send_bits(8'h11, 1'b1);
    repeat (4) tick();
    sbq.push_back(8'h22);
    send_bits(8'h22, 1'b1);
    ready = 1'b1; tick(); ready = 1'b0;
    repeat (3) tick();
    chk("coin_ov", ov_cnt - ov0, 0);
    chk("coin_valid", valid, 1);
    chk("coin_data", data, 8'h22);
    ready = 1'b1; tick(); ready = 1'b0;
    chk("coin_drain_valid", valid, 0);
    chk("final_sbq", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port rx  input  1  asynchronous serial line; idles high.
REQ-005 SHALL provide port data  output  8  received byte, held stable while valid=1.
REQ-006 SHALL provide port valid  output  1  data holds an unconsumed byte.
REQ-007 SHALL provide port ready  input  1  consumer accepts data on any edge where valid=1 and ready=1.
REQ-008 SHALL provide port framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL provide port overrun  output  1  one-cycle pulse when a good byte is dropped because the holding register is full.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (rx_s); synchronizer flops reset to 1.
REQ-011 SHALL use frame format 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1.
REQ-012 SHALL implement the states IDLE, START, DATA and STOP.
REQ-013 SHALL leave IDLE for START only on a 1->0 transition of rx_s (edge edge); a line held low never re-arms reception; that edge is cycle t0.
REQ-014 SHALL sample bit k (k=0 start, 1..8 data, 9 stop) at edge t0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT, using one down/up counter of width clog2(CLKS_PER_BIT)+1.
REQ-015 SHALL, in START, return to IDLE with no output effect if rx_s=1 at the start sample (false start/glitch).
REQ-016 SHALL, in DATA, shift each sample into bit position k-1 of the shift register; a 3-bit index counts data bits 0..7; after bit 8, go to STOP.
REQ-017 SHALL, in STOP, on the stop sample: if rx_s=1, deliver the byte (REQ-018..020); if rx_s=0, pulse framing_error for exactly one cycle and discard the byte; return to IDLE in both cases on the same edge.
REQ-018 SHALL, on delivery with valid=0, load data and set valid=1 on the stop-sample edge, so data is visible the cycle after it.
REQ-019 SHALL, on delivery with valid=1 and ready=1 on the same edge, accept the old byte, load the new byte, keep valid=1 and not pulse overrun.
REQ-020 SHALL, on delivery with valid=1 and ready=0, keep the old data, drop the new byte and pulse overrun for one cycle.
REQ-021 SHALL clear valid on an edge where valid=1, ready=1 and no delivery occurs; ready while valid=0 has no effect.
REQ-022 SHALL keep data unchanged except on a load (REQ-018/019).
REQ-023 SHALL detect a new start edge in the cycle immediately after returning to IDLE, supporting back-to-back frames.
REQ-024 SHALL never assert framing_error and overrun on the same edge.

Reset
REQ-025 SHALL, while rst=1 at an edge, set state=IDLE, counters=0, shift register=0, data=8'h00, valid=0, framing_error=0, overrun=0 and synchronizer flops=1.
REQ-026 SHALL, on rst mid-frame, abandon the partial byte with no valid, framing_error or overrun pulse.
REQ-027 SHALL, after rst deasserts, require a fresh 1->0 edge on rx_s before receiving.

Verification (CLKS_PER_BIT=4)
REQ-028 SHALL check frame 0xAA with ready=1 -> valid=1 for one cycle with data=8'hAA, no error pulses.
REQ-029 SHALL check frames 0x5C then 0x3F back-to-back with ready=0 -> data=8'h5C held, valid=1, overrun pulses once; then ready=1 for one cycle -> valid=0.
REQ-030 SHALL check rx low for 1 cycle then high -> FSM returns to IDLE, no valid and no framing_error.
REQ-031 SHALL check frame 0x81 with stop bit 0 and rx held low for 20 cycles -> one framing_error pulse, valid stays 0, no new frame starts until rx rises and falls again.
REQ-032 SHALL check rst=1 during data bit 4 of frame 0xFF, then a clean frame 0x01 -> no output from the aborted frame, then data=8'h01 and valid=1.
REQ-033 SHALL check a delivery coinciding with ready=1 while valid=1 -> new byte loaded, valid stays 1, no overrun.
